// File: rtl/mlp_layer_seq.sv
// mlp_layer_seq: run-time programmable layer sequencer for the fully-connected
// inference datapath. Streams operand/weight addresses for each layer into the
// PU, waits for the PU to finish, then commits the result to a ping-pong temp
// bank (or to y on the last layer).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; table writable
// CLR    | one-cycle PU accumulator clear before a layer
// STREAM | issuing addresses 0..len-1 to operand and weight buffers
// WAIT   | waiting for the PU to report the layer complete
// WB     | one-cycle commit to temp bank (or y on the last layer)
// DONE   | inference finished; table writable; start allowed again
module mlp_layer_seq #(
  parameter int NUM_LAYERS = 6,
  parameter int ADDR_W     = 10,
  parameter int LAYER_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               cfg_we_i,
  input  logic [LAYER_W-1:0] cfg_layer_i,
  input  logic [ADDR_W-1:0]  cfg_len_i,
  input  logic               pu_done_i,
  output logic               src_en_o,
  output logic [1:0]         src_sel_o,
  output logic [ADDR_W-1:0]  src_addr_o,
  output logic               w_en_o,
  output logic [LAYER_W-1:0] w_sel_o,
  output logic [ADDR_W-1:0]  w_addr_o,
  output logic               acc_clr_o,
  output logic               pu_valid_o,
  output logic               pu_last_o,
  output logic               wb_en_o,
  output logic               wb_sel_o,
  output logic               y_wen_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic               busy_o,
  output logic               err_o,
  output logic               done_intr_o,
  output logic               done_led_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q [NUM_LAYERS];
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic                pu_valid_q, pu_valid_d;
  logic                pu_last_q, pu_last_d;
  logic                err_q, err_d;
  logic                done_intr_q, done_intr_d;
  logic                done_led_q, done_led_d;

  logic                busy;
  logic                tbl_ok;
  logic                start_ok;
  logic [ADDR_W-1:0]   cur_len;
  logic                last_beat;
  logic                last_layer;
  logic                cfg_idx_ok;

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cur_len    = len_q[layer_q];
  // Compare against len-1 so a full-range length never needs count to wrap.
  assign last_beat  = (count_q == (cur_len - ADDR_W'(1)));
  assign last_layer = (layer_q == LAYER_W'(NUM_LAYERS - 1));
  assign cfg_idx_ok = (32'(cfg_layer_i) < NUM_LAYERS);

  // Table is only startable when every layer has a nonzero length.
  always_comb begin
    tbl_ok = 1'b1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (len_q[i] == '0) tbl_ok = 1'b0;
    end
  end

  // Layer-length table; writes blocked while a run is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) len_q[i] <= '0;
    end else if (cfg_we_i && !busy && cfg_idx_ok) begin
      len_q[cfg_layer_i] <= cfg_len_i;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition while busy.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          if (tbl_ok) begin
            start_ok = 1'b1;
            state_d  = S_CLR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLR:    state_d = S_STREAM;
      S_STREAM: if (last_beat) state_d = S_WAIT;
      // The pu_last cycle cannot complete the layer: the final sample is
      // only just arriving at the PU.
      S_WAIT:   if (pu_done_i && !pu_last_q) state_d = S_WB;
      S_WB:     state_d = last_layer ? S_DONE : S_CLR;
      default:  state_d = S_IDLE;
    endcase
    if (abort_i && busy) state_d = S_IDLE;
  end

  // Datapath next values: counter, layer index, delayed valid/last, flags.
  always_comb begin
    count_d     = (state_q == S_STREAM) ? count_q + ADDR_W'(1) : '0;
    layer_d     = layer_q;
    pu_valid_d  = (state_q == S_STREAM) && !abort_i;
    pu_last_d   = (state_q == S_STREAM) && last_beat && !abort_i;
    done_intr_d = 1'b0;
    done_led_d  = done_led_q;
    if (start_ok) begin
      layer_d    = '0;
      done_led_d = 1'b0;
    end
    if (state_q == S_WB && !abort_i) begin
      if (last_layer) begin
        done_intr_d = 1'b1;
        done_led_d  = 1'b1;
      end else begin
        layer_d = layer_q + LAYER_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      layer_q     <= '0;
      pu_valid_q  <= 1'b0;
      pu_last_q   <= 1'b0;
      err_q       <= 1'b0;
      done_intr_q <= 1'b0;
      done_led_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      layer_q     <= layer_d;
      pu_valid_q  <= pu_valid_d;
      pu_last_q   <= pu_last_d;
      err_q       <= err_d;
      done_intr_q <= done_intr_d;
      done_led_q  <= done_led_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    src_en_o   = 1'b0;
    src_sel_o  = 2'b00;
    src_addr_o = '0;
    w_en_o     = 1'b0;
    w_sel_o    = '0;
    w_addr_o   = '0;
    acc_clr_o  = 1'b0;
    wb_en_o    = 1'b0;
    wb_sel_o   = 1'b0;
    y_wen_o    = 1'b0;
    unique case (state_q)
      S_CLR: acc_clr_o = 1'b1;
      S_STREAM: begin
        src_en_o   = 1'b1;
        src_addr_o = count_q;
        w_en_o     = 1'b1;
        w_addr_o   = count_q;
        w_sel_o    = layer_q;
        // Layer k reads the bank that layer k-1 wrote: odd k -> A, even k -> B.
        if (layer_q == '0)  src_sel_o = 2'b00;
        else if (layer_q[0]) src_sel_o = 2'b01;
        else                 src_sel_o = 2'b10;
      end
      S_WB: begin
        if (last_layer) begin
          y_wen_o = 1'b1;
        end else begin
          wb_en_o  = 1'b1;
          wb_sel_o = layer_q[0];
        end
      end
      default: ;
    endcase
  end

  assign pu_valid_o  = pu_valid_q;
  assign pu_last_o   = pu_last_q;
  assign layer_o     = layer_q;
  assign busy_o      = busy;
  assign err_o       = err_q;
  assign done_intr_o = done_intr_q;
  assign done_led_o  = done_led_q;

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Testbench for mlp_layer_seq: a monitor captures one record per committed
// layer; the stimulus pushes the records it expects and compares them.
module tb_mlp_layer_seq;

  localparam int NL = 6;
  localparam int AW = 10;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, cfg_we_i = 1'b0;
  logic [LW-1:0] cfg_layer_i = '0;
  logic [AW-1:0] cfg_len_i = '0;
  logic          pu_done_i;
  logic          pu_done_auto = 1'b0, pu_done_man = 1'b0;
  logic          src_en_o, w_en_o, acc_clr_o, pu_valid_o, pu_last_o;
  logic          wb_en_o, wb_sel_o, y_wen_o, busy_o, err_o, done_intr_o, done_led_o;
  logic [1:0]    src_sel_o;
  logic [AW-1:0] src_addr_o, w_addr_o;
  logic [LW-1:0] w_sel_o, layer_o;

  assign pu_done_i = pu_done_auto | pu_done_man;

  mlp_layer_seq #(.NUM_LAYERS(NL), .ADDR_W(AW), .LAYER_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_we_i(cfg_we_i), .cfg_layer_i(cfg_layer_i), .cfg_len_i(cfg_len_i),
    .pu_done_i(pu_done_i), .src_en_o(src_en_o), .src_sel_o(src_sel_o),
    .src_addr_o(src_addr_o), .w_en_o(w_en_o), .w_sel_o(w_sel_o),
    .w_addr_o(w_addr_o), .acc_clr_o(acc_clr_o), .pu_valid_o(pu_valid_o),
    .pu_last_o(pu_last_o), .wb_en_o(wb_en_o), .wb_sel_o(wb_sel_o),
    .y_wen_o(y_wen_o), .layer_o(layer_o), .busy_o(busy_o), .err_o(err_o),
    .done_intr_o(done_intr_o), .done_led_o(done_led_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int layer;
    int len;
    int sel;
    int wb;         // 0/1 temp bank, 2 = y write
    int last_addr;  // address whose delayed sample carried pu_last
    int bad;        // address/enable/lag inconsistency seen in the layer
  } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   rd_idx = 0;
  int   busy_cnt = 0, intr_cnt = 0, err_cnt = 0, idle_en_cnt = 0;
  int   checks = 0, failures = 0;
  int   tbl [NL];
  bit   pu_auto = 1'b0;
  int   pu_delay = 2;

  // PU model: answers each pu_last with a one-cycle done after pu_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (pu_auto && pu_last_o) begin
        repeat (pu_delay) @(negedge clk);
        pu_done_auto = 1'b1;
        @(negedge clk);
        pu_done_auto = 1'b0;
      end
    end
  end

  // Monitor: builds one record per layer, pushed on the wb/y commit pulse.
  initial begin
    rec_t cur;
    bit   prev_en;
    int   prev_addr;
    cur = '{layer: 0, len: 0, sel: -1, wb: 0, last_addr: -1, bad: 0};
    prev_en = 1'b0;
    prev_addr = 0;
    forever begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_intr_o) intr_cnt++;
      if (err_o) err_cnt++;
      if (!busy_o && (src_en_o || w_en_o || acc_clr_o || wb_en_o || y_wen_o || pu_valid_o))
        idle_en_cnt++;
      if (acc_clr_o) cur = '{layer: int'(layer_o), len: 0, sel: -1, wb: 0, last_addr: -1, bad: 0};
      if (pu_valid_o !== prev_en) cur.bad = 1;
      if (pu_last_o) begin
        if (!prev_en || cur.last_addr != -1) cur.bad = 1;
        cur.last_addr = prev_addr;
      end
      if (src_en_o) begin
        if (int'(src_addr_o) != cur.len || int'(w_addr_o) != cur.len || w_en_o !== 1'b1 ||
            int'(w_sel_o) != cur.layer || int'(layer_o) != cur.layer)
          cur.bad = 1;
        if (cur.sel == -1) cur.sel = int'(src_sel_o);
        else if (cur.sel != int'(src_sel_o)) cur.bad = 1;
        cur.len++;
      end else if (w_en_o) begin
        cur.bad = 1;
      end
      if (wb_en_o) begin
        cur.wb = int'(wb_sel_o);
        obs_q.push_back(cur);
      end
      if (y_wen_o) begin
        cur.wb = 2;
        obs_q.push_back(cur);
      end
      prev_en = src_en_o;
      prev_addr = int'(src_addr_o);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int l, input int len);
    cfg_we_i = 1'b1;
    cfg_layer_i = LW'(l);
    cfg_len_i = AW'(len);
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic load_table(input int l0, input int l1, input int l2,
                            input int l3, input int l4, input int l5);
    tbl = '{l0, l1, l2, l3, l4, l5};
    for (int i = 0; i < NL; i++) cfg(i, tbl[i]);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Expected records for layers 0..n-1 of the current table.
  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) begin
      rec_t e;
      e.layer = k;
      e.len = tbl[k];
      e.sel = (k == 0) ? 0 : ((k % 2 == 1) ? 1 : 2);
      e.wb = (k < NL - 1) ? (k % 2) : 2;
      e.last_addr = tbl[k] - 1;
      e.bad = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_intr_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, int'(seen), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_records(input string tag);
    while (exp_q.size() > 0) begin
      rec_t e, o;
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        o = obs_q[rd_idx];
        rd_idx++;
        chk($sformatf("%s_L%0d_layer", tag, e.layer), o.layer, e.layer);
        chk($sformatf("%s_L%0d_len", tag, e.layer), o.len, e.len);
        chk($sformatf("%s_L%0d_src_sel", tag, e.layer), o.sel, e.sel);
        chk($sformatf("%s_L%0d_commit", tag, e.layer), o.wb, e.wb);
        chk($sformatf("%s_L%0d_last_addr", tag, e.layer), o.last_addr, e.last_addr);
        chk($sformatf("%s_L%0d_stream_ok", tag, e.layer), o.bad, e.bad);
      end else begin
        chk($sformatf("%s_L%0d_missing", tag, e.layer), obs_q.size(), rd_idx + 1);
      end
    end
    chk({tag, "_extra_records"}, obs_q.size(), rd_idx);
  endtask

  initial begin
    int b0, e0, i0, n0;
    bit hit, early;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        int'({src_en_o, src_sel_o, src_addr_o, w_en_o, w_sel_o, w_addr_o, acc_clr_o,
              pu_valid_o, pu_last_o, wb_en_o, wb_sel_o, y_wen_o, busy_o, err_o,
              done_intr_o, done_led_o}), 0);
    chk("reset_layer", int'(layer_o), 0);

    // Start with the all-zero reset table is rejected
    e0 = err_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("zero_table_err", err_cnt - e0, 1);
    chk("zero_table_busy", busy_cnt, 0);

    // Full 6-layer inference, PU done 2 cycles after pu_last
    load_table(784, 64, 32, 32, 16, 10);
    pu_auto = 1'b1;
    pu_delay = 2;
    b0 = busy_cnt; i0 = intr_cnt;
    push_expected(NL);
    pulse_start();
    wait_done("run1_done", 3000);
    check_records("run1");
    chk("run1_busy_cycles", busy_cnt - b0, 968);
    repeat (5) @(negedge clk);
    chk("run1_intr_pulses", intr_cnt - i0, 1);
    chk("run1_led", int'(done_led_o), 1);
    chk("run1_idle_enables", idle_en_cnt, 0);

    // Zero entry rejected from DONE; state and led unchanged
    cfg(3, 0);
    b0 = busy_cnt; e0 = err_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    chk("zero_entry_err", err_cnt - e0, 1);
    chk("zero_entry_busy", busy_cnt - b0, 0);
    chk("zero_entry_led", int'(done_led_o), 1);
    chk("zero_entry_idle_enables", idle_en_cnt, 0);
    cfg(3, 32);

    // Abort in layer 2 at count 5
    i0 = intr_cnt;
    push_expected(2);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (layer_o == 3'd2 && src_en_o && src_addr_o == 10'd5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_point_reached", int'(hit), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_enables", int'({src_en_o, w_en_o, pu_valid_o, wb_en_o, y_wen_o}), 0);
    repeat (10) @(negedge clk);
    check_records("abort");
    chk("abort_no_intr", intr_cnt - i0, 0);
    chk("abort_led", int'(done_led_o), 0);

    // Restart after abort runs cleanly from layer 0
    i0 = intr_cnt;
    push_expected(NL);
    pulse_start();
    wait_done("restart_done", 3000);
    check_records("restart");
    chk("restart_intr", intr_cnt - i0, 1);

    // pu_done ignored in STREAM and on the pu_last cycle; busy cfg write ignored
    load_table(4, 3, 3, 3, 3, 3);
    pu_auto = 1'b0;
    pu_delay = 1;
    push_expected(NL);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src_en_o) begin
        hit = 1'b1;
        break;
      end
    end
    chk("pd_stream_seen", int'(hit), 1);
    pu_done_man = 1'b1;
    @(negedge clk);
    pu_done_man = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pu_last_o) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pd_last_seen", int'(hit), 1);
    pu_done_man = 1'b1;
    @(negedge clk);
    pu_done_man = 1'b0;
    early = wb_en_o;
    repeat (3) begin
      @(negedge clk);
      early = early | wb_en_o;
    end
    chk("pd_no_early_wb", int'(early), 0);
    pu_done_man = 1'b1;
    @(negedge clk);
    chk("pd_wb_after_held_done", int'(wb_en_o), 1);
    pu_done_man = 1'b0;
    pu_auto = 1'b1;
    cfg(0, 5);
    wait_done("pd_done", 500);
    check_records("pd");

    // Busy-time write had no effect on the table
    push_expected(NL);
    pulse_start();
    wait_done("busywr_done", 500);
    check_records("busywr");

    // Same write from DONE is accepted
    cfg(0, 5);
    tbl[0] = 5;
    push_expected(NL);
    pulse_start();
    wait_done("donewr_done", 500);
    check_records("donewr");

    // Full-range layer length: addresses 0..1022, no wrap
    load_table(1023, 1, 1, 1, 1, 1);
    n0 = obs_q.size();
    push_expected(NL);
    pulse_start();
    wait_done("maxlen_done", 3000);
    check_records("maxlen");
    chk("maxlen_records", obs_q.size() - n0, NL);
    chk("final_idle_enables", idle_en_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlp_layer_seq.md
# mlp_layer_seq

Parametrised layer sequencer for the fully-connected inference datapath. It replaces a fixed-topology controller with a run-time programmable table of per-layer input lengths. For each layer it streams operands from the x buffer or a ping-pong temp buffer, together with the matching weight bank, into the processing unit, then commits the result to temp or y. It sits between the host/start logic and the buffer/PU datapath.

## Interface
- NUM_LAYERS, 6, number of layers in the table (2..8)
- ADDR_W, 10, operand/weight address width; max layer length 2^ADDR_W-1
- LAYER_W, 3, width of layer index
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  begin inference (honoured in IDLE or DONE)
- abort_i  in  1  abandon current inference
- cfg_we_i  in  1  write layer-length table entry
- cfg_layer_i  in  LAYER_W  table index
- cfg_len_i  in  ADDR_W  input-vector length of that layer
- pu_done_i  in  1  PU finished current layer
- src_en_o  out  1  operand buffer read enable
- src_sel_o  out  2  00 x buffer, 01 temp bank A, 10 temp bank B
- src_addr_o  out  ADDR_W  operand address
- w_en_o  out  1  weight read enable
- w_sel_o  out  LAYER_W  weight bank select (= layer index)
- w_addr_o  out  ADDR_W  weight address
- acc_clr_o  out  1  PU accumulator clear
- pu_valid_o  out  1  operand/weight data valid at PU input
- pu_last_o  out  1  last valid sample of layer
- wb_en_o  out  1  temp-buffer write enable
- wb_sel_o  out  1  0 bank A, 1 bank B
- y_wen_o  out  1  y buffer write enable
- layer_o  out  LAYER_W  current layer index
- busy_o  out  1  high in any state except IDLE/DONE
- err_o  out  1  one-cycle pulse: start rejected
- done_intr_o  out  1  one-cycle pulse at completion
- done_led_o  out  1  level; high from completion until next accepted start

## Operation
- States: IDLE, CLR, STREAM, WAIT, WB, DONE. Reset: IDLE; all outputs 0; table entries 0; layer/count 0.
- Table writes are accepted only while busy_o=0. Writes with cfg_layer_i >= NUM_LAYERS are ignored.
- IDLE/DONE + start_i:
  - If any entry 0..NUM_LAYERS-1 is 0: pulse err_o and stay in the current state.
  - Otherwise: layer=0 and go to CLR. done_led_o clears.
- CLR (1 cycle): acc_clr_o=1, count=0 → STREAM.
- STREAM (len cycles, count 0..len-1):
  - src_en_o=w_en_o=1, src_addr_o=w_addr_o=count, w_sel_o=layer.
  - src_sel_o=00 for layer 0. For layer k>0, it is the bank written by layer k-1.
  - After count=len-1 → WAIT.
- pu_valid_o is src_en_o delayed one cycle (1-cycle buffer read latency). pu_last_o marks the delayed final sample.
- WAIT: holds until pu_done_i=1 → WB. pu_done_i is ignored in every other state and in the WAIT cycle where pu_last_o=1.
- WB (1 cycle):
  - Layer k < NUM_LAYERS-1: wb_en_o=1, wb_sel_o=k[0] (even→A, odd→B), layer+1 → CLR.
  - Last layer: y_wen_o=1 → DONE.
- DONE: done_intr_o pulses on the entry cycle. done_led_o is held.
- abort_i in any busy state → IDLE next cycle, all enables low. No done_intr_o; done_led_o unchanged. Priority: rst_n > abort_i > start_i/pu_done_i.
- start_i while busy is ignored.

## Timing
- Layer cycles = 1 (CLR) + len + 1 + D + 1 (WB), where D ≥ 0 is the number of WAIT cycles after the pu_last_o cycle.
- src/w address and enable change on the same edge. pu_valid_o/pu_last_o lag by exactly 1 cycle.
- layer_o is updated on the WB→CLR edge and is stable for a whole layer.
- err_o, done_intr_o, acc_clr_o, wb_en_o and y_wen_o are single-cycle pulses.
- count width is ADDR_W. len = 2^ADDR_W-1 is legal and must not wrap before the last address.

## Test plan
- Table {784,64,32,32,16,10}, PU returning done 2 cycles after pu_last_o, start:
  - STREAM lasts 784/64/32/32/16/10 cycles.
  - src_sel sequence 00,01,10,01,10,01; wb_sel sequence 0,1,0,1,0; one y_wen_o pulse.
  - done_intr_o is 1 cycle; done_led_o stays high.
- Table entry 3 = 0, start: err_o pulse, busy_o stays 0, no enables asserted.
- abort_i in layer 2 at count 5: IDLE next cycle, no wb/y writes, no done_intr_o. A restart then runs cleanly from layer 0.
- pu_done_i pulsed during STREAM and on the pu_last_o cycle: both ignored. Held done 4 cycles later → WB.
- cfg write during busy (layer 0 len 5) is ignored. Same write after DONE is accepted; start from DONE gives STREAM of 5 cycles.
- Single layer len 1023 (ADDR_W=10): addresses 0..1022 with no wrap; pu_last_o at address 1022 plus 1 cycle.
